// File: rtl/key_pkg.sv
// Shared types and constants for the front-panel key conditioner.
package key_pkg;

   // Per-channel debounce / hold state.
   typedef enum logic [2:0] {
      IDLE,
      PRESS_DB,
      HELD,
      LONG,
      REL_DB
   } key_state_t;

   // Default timing for a 50 MHz system clock.
   localparam int DEF_DEBOUNCE_CYC = 1000000;   // 20 ms
   localparam int DEF_LONG_CYC     = 50000000;  // 1 s
   localparam int DEF_REPEAT_CYC   = 10000000;  // 200 ms

   // Counter width able to hold the largest of the three interval values.
   function automatic int key_cnt_w(input int db, input int lg, input int rp);
      int m;
      m = db;
      if (lg > m) m = lg;
      if (rp > m) m = rp;
      return ($clog2(m + 1) < 1) ? 1 : $clog2(m + 1);
   endfunction

endpackage

// File: rtl/key_debounce_chan.sv
// One key channel: 2-flop synchroniser, debounce/hold FSM, interval counter
// and registered level / pulse outputs.
module key_debounce_chan
   import key_pkg::*;
#(
   parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
   parameter int LONG_CYC     = DEF_LONG_CYC,
   parameter int REPEAT_CYC   = DEF_REPEAT_CYC,
   parameter int ACTIVE_LOW   = 1
) (
   input  logic clk,
   input  logic rstn,
   input  logic en,
   input  logic key_raw,
   output logic key_level,
   output logic press_pulse,
   output logic release_pulse,
   output logic long_pulse,
   output logic repeat_pulse,
   output logic level_next
);

   localparam int CW = key_cnt_w(DEBOUNCE_CYC, LONG_CYC, REPEAT_CYC);
   localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYC - 1);
   localparam logic [CW-1:0] LONG_LAST = (LONG_CYC == 0) ? '0 : CW'(LONG_CYC - 1);
   localparam logic [CW-1:0] REP_LAST  = (REPEAT_CYC == 0) ? '0 : CW'(REPEAT_CYC - 1);
   // Pin level of a released key.
   localparam logic REL_PIN = (ACTIVE_LOW != 0);

   logic          key_meta;
   logic          key_s;
   logic          pressed;
   key_state_t    state;
   key_state_t    state_next;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_next;
   logic          long_flag;
   logic          long_flag_next;
   logic          press_next;
   logic          release_next;
   logic          long_next;
   logic          repeat_next;

   assign pressed = key_s ^ REL_PIN;

   // Synchroniser; a cleared channel restarts from the released pin level.
   always_ff @(posedge clk) begin
      if (!rstn || !en) begin
         key_meta <= REL_PIN;
         key_s    <= REL_PIN;
      end else begin
         key_meta <= key_raw;
         key_s    <= key_meta;
      end
   end

   // State register plus registered outputs; en low clears like reset.
   always_ff @(posedge clk) begin
      if (!rstn || !en) begin
         state         <= IDLE;
         cnt           <= '0;
         long_flag     <= 1'b0;
         key_level     <= 1'b0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         long_pulse    <= 1'b0;
         repeat_pulse  <= 1'b0;
      end else begin
         state         <= state_next;
         cnt           <= cnt_next;
         long_flag     <= long_flag_next;
         key_level     <= level_next;
         press_pulse   <= press_next;
         release_pulse <= release_next;
         long_pulse    <= long_next;
         repeat_pulse  <= repeat_next;
      end
   end

   // Next state and counter; the counter restarts on every state change.
   always_comb begin
      state_next     = state;
      cnt_next       = cnt + 1'b1;
      long_flag_next = long_flag;
      unique case (state)
         IDLE: begin
            cnt_next = '0;
            if (pressed) state_next = PRESS_DB;
         end
         PRESS_DB: begin
            if (!pressed) begin
               state_next = IDLE;
               cnt_next   = '0;
            end else if (cnt == DB_LAST) begin
               state_next = HELD;
               cnt_next   = '0;
            end
         end
         HELD: begin
            if (!pressed) begin
               state_next = REL_DB;
               cnt_next   = '0;
            end else if (LONG_CYC != 0 && cnt == LONG_LAST) begin
               state_next     = LONG;
               cnt_next       = '0;
               long_flag_next = 1'b1;
            end
         end
         LONG: begin
            if (!pressed) begin
               state_next = REL_DB;
               cnt_next   = '0;
            end else if (REPEAT_CYC != 0 && cnt == REP_LAST) begin
               cnt_next = '0;
            end
         end
         REL_DB: begin
            if (pressed) begin
               // Release bounce: resume the hold phase we came from.
               state_next = long_flag ? LONG : HELD;
               cnt_next   = '0;
            end else if (cnt == DB_LAST) begin
               state_next     = IDLE;
               cnt_next       = '0;
               long_flag_next = 1'b0;
            end
         end
         default: begin
            state_next     = IDLE;
            cnt_next       = '0;
            long_flag_next = 1'b0;
         end
      endcase
   end

   // Output decode; values are registered one edge later alongside the state.
   always_comb begin
      press_next   = (state == PRESS_DB) && pressed && (cnt == DB_LAST);
      release_next = (state == REL_DB) && !pressed && (cnt == DB_LAST);
      long_next    = (state == HELD) && pressed && (LONG_CYC != 0) && (cnt == LONG_LAST);
      repeat_next  = (state == LONG) && pressed && (REPEAT_CYC != 0) && (cnt == REP_LAST);
      level_next   = (state_next == HELD) || (state_next == LONG) || (state_next == REL_DB);
   end

endmodule

// File: rtl/key_debounce_array.sv
// N independent key channels plus a registered "any key pressed" flag.
module key_debounce_array
   import key_pkg::*;
#(
   parameter int N_KEYS       = 4,
   parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
   parameter int LONG_CYC     = DEF_LONG_CYC,
   parameter int REPEAT_CYC   = DEF_REPEAT_CYC,
   parameter int ACTIVE_LOW   = 1
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              en,
   input  logic [N_KEYS-1:0] key_raw,
   output logic [N_KEYS-1:0] key_level,
   output logic [N_KEYS-1:0] press_pulse,
   output logic [N_KEYS-1:0] release_pulse,
   output logic [N_KEYS-1:0] long_pulse,
   output logic [N_KEYS-1:0] repeat_pulse,
   output logic              key_any
);

   logic [N_KEYS-1:0] level_next;

   generate
      for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_chan
         key_debounce_chan #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC),
            .LONG_CYC     (LONG_CYC),
            .REPEAT_CYC   (REPEAT_CYC),
            .ACTIVE_LOW   (ACTIVE_LOW)
         ) u_chan (
            .clk           (clk),
            .rstn          (rstn),
            .en            (en),
            .key_raw       (key_raw[gi]),
            .key_level     (key_level[gi]),
            .press_pulse   (press_pulse[gi]),
            .release_pulse (release_pulse[gi]),
            .long_pulse    (long_pulse[gi]),
            .repeat_pulse  (repeat_pulse[gi]),
            .level_next    (level_next[gi])
         );
      end
   endgenerate

   // key_any built from next levels so it changes in the same cycle as key_level.
   always_ff @(posedge clk) begin
      if (!rstn || !en) key_any <= 1'b0;
      else              key_any <= |level_next;
   end

endmodule
